// File: rtl/mips_data_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_data_ram : CPU data RAM with power-on clearing sweep & error flags  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module mips_data_ram #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        clk_enable,
  output logic        err_misaligned,
  output logic        err_range,
  output logic        err_conflict,
  output logic [15:0] write_count
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] sweep_idx;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [32:0]   offset;
  logic          in_range;
  logic          aligned;
  logic          access;
  logic          running;
  logic          commit;
  logic [AW-1:0] word_idx;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  // 33-bit offset: an address below BASE_ADDR goes negative, i.e. >= 2^32 > SPAN
  assign offset   = {1'b0, data_address} - {1'b0, BASE_ADDR};
  assign in_range = (offset < SPAN);
  assign word_idx = AW'(offset >> 2);
  assign aligned  = (data_address[1:0] == 2'b00);
  assign access   = data_read | data_write;
  assign running  = (state == RUN);
  assign commit   = running & data_write & in_range & aligned;

  assign clk_enable    = running;
  assign data_readdata = (running && data_read && in_range) ? mem[word_idx] : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (state == INIT && sweep_idx == AW'(DEPTH_WORDS - 1)) begin
      state_next = RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sweep_idx <= '0;
    end else if (state == INIT) begin
      sweep_idx <= sweep_idx + AW'(1);
    end
  end

  // The single write port is owned by the sweep during INIT, by the CPU in RUN
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = sweep_idx;
    mem_wdata = 32'h0;
    if (state == INIT) begin
      mem_we = 1'b1;
    end else if (commit) begin
      mem_we    = 1'b1;
      mem_waddr = word_idx;
      mem_wdata = data_writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_misaligned <= 1'b0;
      err_range      <= 1'b0;
      err_conflict   <= 1'b0;
      write_count    <= 16'h0;
    end else if (running) begin
      if (access && !aligned)        err_misaligned <= 1'b1;
      if (access && !in_range)       err_range      <= 1'b1;
      if (data_read && data_write)   err_conflict   <= 1'b1;
      if (commit && write_count != 16'hFFFF) begin
        write_count <= write_count + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_data_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mips_data_ram : vector table, reset sequences and random model checks |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_mips_data_ram;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_address = 32'h0;
  logic        data_write = 1'b0;
  logic        data_read = 1'b0;
  logic [31:0] data_writedata = 32'h0;
  logic [31:0] data_readdata;
  logic        clk_enable;
  logic        err_misaligned;
  logic        err_range;
  logic        err_conflict;
  logic [15:0] write_count;

  int n_cmp = 0;
  int n_bad = 0;

  mips_data_ram #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .data_address   (data_address),
    .data_write     (data_write),
    .data_read      (data_read),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata),
    .clk_enable     (clk_enable),
    .err_misaligned (err_misaligned),
    .err_range      (err_range),
    .err_conflict   (err_conflict),
    .write_count    (write_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [2:0]  exp_flags;   // {conflict, range, misaligned}
    int          exp_cnt;
  } vec_t;

  vec_t vecs[12];

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  bit          ref_mis, ref_rng, ref_conf;
  int          ref_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {29'h0, err_conflict, err_range, err_misaligned};
  endfunction

  function automatic bit ref_in_range(input logic [31:0] a);
    longint al, bl;
    al = longint'({32'h0, a});
    bl = longint'({32'h0, BASE});
    return (al >= bl) && (al < bl + 4 * DEPTH);
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    ref_mis = 0; ref_rng = 0; ref_conf = 0; ref_cnt = 0;
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    data_read = rd; data_write = wr; data_address = a; data_writedata = wd;
  endtask

  // Count negedges with clk_enable low, starting right after reset release
  task automatic wait_init(output int n);
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (clk_enable) break;
      n++;
    end
    @(posedge clk); #1;
  endtask

  // One RUN cycle compared against the model, then the model absorbs the edge
  task automatic run_cycle(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    bit inr, al;
    int idx;
    logic [31:0] exp_rd;
    drive(rd, wr, a, wd);
    inr = ref_in_range(a);
    al  = (a[1:0] == 2'b00);
    idx = inr ? int'((a - BASE) / 4) : 0;
    exp_rd = (rd && inr) ? ref_mem[idx] : 32'h0;
    @(negedge clk);
    chk("rnd_rdata", data_readdata, exp_rd);
    chk("rnd_flags", flags(), {29'h0, ref_conf, ref_rng, ref_mis});
    chk("rnd_count", {16'h0, write_count}, ref_cnt);
    @(posedge clk);
    if (wr && inr && al) begin
      ref_mem[idx] = wd;
      if (ref_cnt < 65535) ref_cnt++;
    end
    if ((rd || wr) && !al)  ref_mis  = 1;
    if ((rd || wr) && !inr) ref_rng  = 1;
    if (rd && wr)           ref_conf = 1;
    #1;
  endtask

  function automatic logic [31:0] rand_addr(input bit clean);
    int kind, w;
    logic [31:0] a;
    kind = clean ? 0 : $urandom_range(0, 9);
    w = $urandom_range(0, 16);
    if (w == 16) w = DEPTH - 1;
    a = BASE + 32'(w * 4);
    if (kind == 7) a = a + 32'($urandom_range(1, 3));
    else if (kind == 8) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255) * 4);
    else if (kind == 9) a = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,          32'h0,          3'b000, 0};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0a00, 32'h0000_a000,  32'h0,          3'b000, 0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0a00, 32'h0,          32'h0000_a000,  3'b000, 1};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0a02, 32'hcc00_0000,  32'h0,          3'b000, 1};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0a00, 32'h0,          32'h0000_a000,  3'b001, 1};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,          32'h0,          3'b001, 1};
    vecs[6]  = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hdead_beef,  32'h0,          3'b011, 1};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0a00, 32'h1234_5678,  32'h0000_a000,  3'b011, 1};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0a00, 32'h0,          32'h1234_5678,  3'b111, 2};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,          32'h0,          3'b111, 2};
    vecs[10] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,          32'h0,          3'b111, 2};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0a03, 32'h0,          32'h1234_5678,  3'b111, 2};

    // Reset held: outputs at reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clk_enable", {31'h0, clk_enable}, 32'h0);
    chk("rst_rdata", data_readdata, 32'h0);
    chk("rst_flags", flags(), 32'h0);
    chk("rst_count", {16'h0, write_count}, 32'h0);
    reset = 1'b0;
    wait_init(n);
    chk("init_len", n, DEPTH);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd);
      @(negedge clk);
      chk($sformatf("vec%0d_rdata", i), data_readdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d_flags", i), flags(), {29'h0, vecs[i].exp_flags});
      chk($sformatf("vec%0d_count", i), {16'h0, write_count}, vecs[i].exp_cnt);
      chk($sformatf("vec%0d_clk_enable", i), {31'h0, clk_enable}, 32'h1);
      @(posedge clk); #1;
    end

    // Reset in RUN with a live read of a written word: immediate clear
    drive(1'b1, 1'b0, 32'h0000_0a00, 32'h0);
    #2;
    chk("run_pre_rst_rdata", data_readdata, 32'h1234_5678);
    reset = 1'b1;
    #1;
    chk("run_rst_clk_enable", {31'h0, clk_enable}, 32'h0);
    chk("run_rst_rdata", data_readdata, 32'h0);
    chk("run_rst_flags", flags(), 32'h0);
    chk("run_rst_count", {16'h0, write_count}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    wait_init(n);
    chk("run_rst_init_len", n, DEPTH);
    drive(1'b1, 1'b0, 32'h0000_0a00, 32'h0);
    @(negedge clk);
    chk("run_rst_word_cleared", data_readdata, 32'h0);
    @(posedge clk); #1;

    // Reset mid-INIT with CPU traffic during INIT that must be ignored
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b1, 1'b1, 32'h0000_0012, 32'hffff_ffff);
    repeat (500) @(posedge clk);
    #1;
    @(negedge clk);
    chk("init_rdata", data_readdata, 32'h0);
    chk("init_flags", flags(), 32'h0);
    chk("init_count", {16'h0, write_count}, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_init_rst_clk_enable", {31'h0, clk_enable}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    wait_init(n);
    chk("mid_init_rst_init_len", n, DEPTH);

    // Random traffic against the model; first phase keeps flags clear
    ref_reset();
    for (int i = 0; i < 400; i++) begin
      bit rd, wr, clean;
      clean = (i < 150);
      rd = $urandom_range(0, 1) == 1;
      wr = $urandom_range(0, 1) == 1;
      if (clean && rd && wr) rd = 0;
      run_cycle(rd, wr, rand_addr(clean), $urandom());
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
